// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
// Shared types and constants for the data memory responder:
//   size_e  - access width as encoded by funct3[1:0] (11 is reserved/illegal)
//   state_e - responder handshake FSM states
//   LANE_MASK_* - byte-lane masks for an access starting at lane 0
//   lane_mask() - maps an access size to its lane-0 byte mask
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [3:0] LANE_MASK_B = 4'b0001;
  localparam logic [3:0] LANE_MASK_H = 4'b0011;
  localparam logic [3:0] LANE_MASK_W = 4'b1111;

  // The illegal size yields an empty mask so nothing can be written by it.
  function automatic logic [3:0] lane_mask(input size_e size);
    case (size)
      SIZE_B:  lane_mask = LANE_MASK_B;
      SIZE_H:  lane_mask = LANE_MASK_H;
      SIZE_W:  lane_mask = LANE_MASK_W;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
// Purely combinational byte-lane steering between the 32-bit storage word and
// the LSB-justified data seen by the initiator.
// Ports:
//   size_i     - access size (byte/half/word, 11 illegal)
//   lane_i     - starting byte lane within the word (already aligned by caller)
//   unsigned_i - zero-extend rather than sign-extend sub-word loads
//   wdata_i    - LSB-justified store data
//   rword_i    - full storage word being read
//   be_o       - per-byte write enables for a store
//   wdata_o    - store data shifted into its byte lanes
//   rdata_o    - load data shifted down to bit 0 and extended
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  shamt;
  logic [31:0] rshift;

  // Stores move the low bytes up to the addressed lanes; loads move the
  // addressed lanes down to bit 0 and then extend according to size.
  always_comb begin
    shamt   = {lane_i, 3'b000};
    be_o    = lane_mask(size_i) << lane_i;
    wdata_o = wdata_i << shamt;
    rshift  = rword_i >> shamt;
    rdata_o = '0;
    case (size_i)
      SIZE_B:  rdata_o = unsigned_i ? {24'h0, rshift[7:0]}
                                    : {{24{rshift[7]}}, rshift[7:0]};
      SIZE_H:  rdata_o = unsigned_i ? {16'h0, rshift[15:0]}
                                    : {{16{rshift[15]}}, rshift[15:0]};
      SIZE_W:  rdata_o = rshift;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Word-organised data memory behind a valid/ready request channel and a
// valid/ready response channel, with a fixed WAIT_CYCLES access delay.
// Loads and stores take effect on the request accept edge; the response
// (extended load data or zero, plus an error flag) follows later.
// Parameters:
//   DEPTH       - number of 32-bit words; word index wraps modulo DEPTH
//   WAIT_CYCLES - cycles spent in WAIT between accept and response
// Ports:
//   clk, reset (synchronous, active low)
//   req_valid/req_ready, req_we, req_addr, req_wdata, req_size, req_unsigned
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err
// Build option:
//   DATA_MEM_RESPONDER_ALIGN_CHECK_EN - misaligned half/word accesses are
//   rejected with rsp_err; otherwise they are silently forced aligned.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  logic [31:0]   mem_q [DEPTH];

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  size_e         size;
  logic          accept;
  logic          access_err;
  logic [1:0]    lane;
  logic [29:0]   word_full;
  logic [AW-1:0] word_idx;
  logic          unused_idx_bits;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   lane_rdata;

  assign size = size_e'(req_size);

  // Ready is gated by reset so nothing is accepted (or written) while the
  // block is held in reset, yet it rises as soon as reset is released.
  assign req_ready = (state_q == IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign word_full       = req_addr[31:2] % 30'(DEPTH);
  assign word_idx        = word_full[AW-1:0];
  assign unused_idx_bits = ^word_full[29:AW];

`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
  logic misaligned;

  // Misaligned half/word accesses are rejected outright.
  always_comb begin
    misaligned = ((size == SIZE_H) && req_addr[0]) ||
                 ((size == SIZE_W) && (req_addr[1:0] != 2'b00));
    access_err = (size == SIZE_X) || misaligned;
    lane       = req_addr[1:0];
  end
`else
  // Misaligned half/word accesses drop the low address bits instead of
  // faulting; only the reserved size code is an error.
  always_comb begin
    access_err = (size == SIZE_X);
    case (size)
      SIZE_H:  lane = {req_addr[1], 1'b0};
      SIZE_W:  lane = 2'b00;
      default: lane = req_addr[1:0];
    endcase
  end
`endif

  mem_lane_align u_align (
    .size_i     (size),
    .lane_i     (lane),
    .unsigned_i (req_unsigned),
    .wdata_i    (req_wdata),
    .rword_i    (mem_q[word_idx]),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata)
  );

  // Storage is never reset; a store lands on its accept edge so an aborted
  // transaction still leaves the write in place.
  always_ff @(posedge clk) begin
    if (accept && req_we && !access_err) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) begin
          mem_q[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response data is captured at accept so later request changes are
  // irrelevant; it stays frozen while the response waits for rsp_ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = (req_we || access_err) ? '0 : lane_rdata;
          err_d   = access_err;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Directed bench for data_mem_responder. One instance uses the default
// WAIT_CYCLES=2, a second uses WAIT_CYCLES=0 for back-to-back traffic.
// Expected values are written out by hand next to each vector.
// Honours DATA_MEM_RESPONDER_ALIGN_CHECK_EN for the misalignment vectors.
module tb_data_mem_responder;

  localparam int EXP_LATENCY = 3;
  localparam int MAX_WAIT    = 20;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  logic        clk;
  logic        reset;

  logic        reqValid, reqReady, reqWe, reqUnsigned;
  logic [31:0] reqAddr, reqWdata;
  logic [1:0]  reqSize;
  logic        rspValid, rspReady, rspErr;
  logic [31:0] rspRdata;

  logic        zReqValid, zReqReady, zReqWe, zReqUnsigned;
  logic [31:0] zReqAddr, zReqWdata;
  logic [1:0]  zReqSize;
  logic        zRspValid, zRspReady, zRspErr;
  logic [31:0] zRspRdata;

  int checkCount;
  int errorCount;

  logic        zWeTab    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] zAddrTab  [4] = '{32'h10, 32'h10, 32'h13, 32'h13};
  logic [31:0] zWdataTab [4] = '{32'h11112222, 32'h0, 32'h00000080, 32'h0};
  logic [1:0]  zSizeTab  [4] = '{2'b10, 2'b10, 2'b00, 2'b00};
  logic [31:0] zExpTab   [4] = '{32'h0, 32'h11112222, 32'h0, 32'hFFFFFF80};

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (reqValid),
    .req_ready    (reqReady),
    .req_we       (reqWe),
    .req_addr     (reqAddr),
    .req_wdata    (reqWdata),
    .req_size     (reqSize),
    .req_unsigned (reqUnsigned),
    .rsp_valid    (rspValid),
    .rsp_ready    (rspReady),
    .rsp_rdata    (rspRdata),
    .rsp_err      (rspErr)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dutZero (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (zReqValid),
    .req_ready    (zReqReady),
    .req_we       (zReqWe),
    .req_addr     (zReqAddr),
    .req_wdata    (zReqWdata),
    .req_size     (zReqSize),
    .req_unsigned (zReqUnsigned),
    .rsp_valid    (zRspValid),
    .rsp_ready    (zRspReady),
    .rsp_rdata    (zRspRdata),
    .rsp_err      (zRspErr)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backstop in case a handshake loop ever misbehaves.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance with rspReady high.
  // Called and returns #1 after a clock edge.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size,
                               input logic uns, input logic [31:0] expRdata,
                               input logic expErr);
    int waited;
    int lat;
    reqWe       = we;
    reqAddr     = addr;
    reqWdata    = wdata;
    reqSize     = size;
    reqUnsigned = uns;
    reqValid    = 1'b1;
    waited = 0;
    while (!reqReady && waited < MAX_WAIT) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput({tag, " req_ready"}, 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    reqValid    = 1'b0;
    reqWe       = ~we;
    reqAddr     = ~addr;
    reqWdata    = ~wdata;
    reqSize     = ~size;
    reqUnsigned = ~uns;
    lat = 1;
    while (!rspValid && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(EXP_LATENCY));
    checkOutput({tag, " rdata"}, rspRdata, expRdata);
    checkOutput({tag, " err"}, 32'(rspErr), 32'(expErr));
    @(posedge clk); #1;
  endtask

  // Accept a request, then pull reset during its WAIT phase.
  task automatic abortInWait(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata);
    reqWe       = we;
    reqAddr     = addr;
    reqWdata    = wdata;
    reqSize     = SZ_W;
    reqUnsigned = 1'b0;
    reqValid    = 1'b1;
    checkOutput({tag, " req_ready"}, 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    reqValid = 1'b0;
    reset    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, " rsp_valid in reset"}, 32'(rspValid), 32'd0);
      checkOutput({tag, " req_ready in reset"}, 32'(reqReady), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, " rsp_valid after release"}, 32'(rspValid), 32'd0);
      checkOutput({tag, " req_ready after release"}, 32'(reqReady), 32'd1);
    end
  endtask

  initial begin
    int lat;
    checkCount   = 0;
    errorCount   = 0;
    reset        = 1'b0;
    reqValid     = 1'b0;
    reqWe        = 1'b0;
    reqAddr      = '0;
    reqWdata     = '0;
    reqSize      = SZ_W;
    reqUnsigned  = 1'b0;
    rspReady     = 1'b1;
    zReqValid    = 1'b0;
    zReqWe       = 1'b0;
    zReqAddr     = '0;
    zReqWdata    = '0;
    zReqSize     = SZ_W;
    zReqUnsigned = 1'b0;
    zRspReady    = 1'b1;

    $display("[TB] reset phase");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset req_ready", 32'(reqReady), 32'd0);
    checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset rsp_rdata", rspRdata, 32'h0);
    checkOutput("reset rsp_err", 32'(rspErr), 32'd0);
    checkOutput("reset zero-wait req_ready", 32'(zReqReady), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("release req_ready", 32'(reqReady), 32'd1);

    $display("[TB] load extension");
    applyStimulus("preload sw 0x64", 1'b1, 32'h64, 32'h8899AABB, SZ_W, 1'b0, 32'h0, 1'b0);
    applyStimulus("lb 0x64",  1'b0, 32'h64, 32'h0, SZ_B, 1'b0, 32'hFFFFFFBB, 1'b0);
    applyStimulus("lbu 0x67", 1'b0, 32'h67, 32'h0, SZ_B, 1'b1, 32'h00000088, 1'b0);
    applyStimulus("lh 0x66",  1'b0, 32'h66, 32'h0, SZ_H, 1'b0, 32'hFFFF8899, 1'b0);
    applyStimulus("lhu 0x64", 1'b0, 32'h64, 32'h0, SZ_H, 1'b1, 32'h0000AABB, 1'b0);
    applyStimulus("lb 0x66",  1'b0, 32'h66, 32'h0, SZ_B, 1'b0, 32'hFFFFFF99, 1'b0);
    applyStimulus("lbu 0x65", 1'b0, 32'h65, 32'h0, SZ_B, 1'b1, 32'h000000AA, 1'b0);
    applyStimulus("lw 0x64",  1'b0, 32'h64, 32'h0, SZ_W, 1'b0, 32'h8899AABB, 1'b0);

    $display("[TB] partial stores");
    applyStimulus("sw 0x64",  1'b1, 32'h64, 32'h00000019, SZ_W, 1'b0, 32'h0, 1'b0);
    applyStimulus("sb 0x65",  1'b1, 32'h65, 32'h000000FF, SZ_B, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw merged", 1'b0, 32'h64, 32'h0, SZ_W, 1'b0, 32'h0000FF19, 1'b0);
    applyStimulus("sh 0x66",  1'b1, 32'h66, 32'h0000BEEF, SZ_H, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw after sh", 1'b0, 32'h64, 32'h0, SZ_W, 1'b0, 32'hBEEFFF19, 1'b0);

    $display("[TB] illegal size");
    applyStimulus("store size 11", 1'b1, 32'h64, 32'hFFFFFFFF, SZ_X, 1'b0, 32'h0, 1'b1);
    applyStimulus("lw after illegal store", 1'b0, 32'h64, 32'h0, SZ_W, 1'b0, 32'hBEEFFF19, 1'b0);
    applyStimulus("load size 11", 1'b0, 32'h64, 32'h0, SZ_X, 1'b0, 32'h0, 1'b1);

    $display("[TB] response backpressure");
    rspReady    = 1'b0;
    reqWe       = 1'b0;
    reqAddr     = 32'h64;
    reqSize     = SZ_W;
    reqUnsigned = 1'b0;
    reqValid    = 1'b1;
    checkOutput("stall req_ready", 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    reqWe    = 1'b1;
    reqWdata = 32'hDEADBEEF;
    lat = 1;
    while (!rspValid && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("stall latency", 32'(lat), 32'(EXP_LATENCY));
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall rsp_valid", 32'(rspValid), 32'd1);
      checkOutput("stall rsp_rdata", rspRdata, 32'hBEEFFF19);
      checkOutput("stall req_ready", 32'(reqReady), 32'd0);
      @(posedge clk); #1;
    end
    reqValid = 1'b0;
    rspReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("stall released rsp_valid", 32'(rspValid), 32'd0);
    applyStimulus("lw after stall", 1'b0, 32'h64, 32'h0, SZ_W, 1'b0, 32'hBEEFFF19, 1'b0);

    $display("[TB] misaligned accesses");
    applyStimulus("sw 0x60 base", 1'b1, 32'h60, 32'h0BADF00D, SZ_W, 1'b0, 32'h0, 1'b0);
`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
    applyStimulus("lw 0x62 rejected", 1'b0, 32'h62, 32'h0, SZ_W, 1'b0, 32'h0, 1'b1);
    applyStimulus("sw 0x62 rejected", 1'b1, 32'h62, 32'h12345678, SZ_W, 1'b0, 32'h0, 1'b1);
    applyStimulus("lh 0x63 rejected", 1'b0, 32'h63, 32'h0, SZ_H, 1'b0, 32'h0, 1'b1);
    applyStimulus("lw 0x60 untouched", 1'b0, 32'h60, 32'h0, SZ_W, 1'b0, 32'h0BADF00D, 1'b0);
`else
    applyStimulus("sw 0x62 forced", 1'b1, 32'h62, 32'h12345678, SZ_W, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw 0x60 forced", 1'b0, 32'h60, 32'h0, SZ_W, 1'b0, 32'h12345678, 1'b0);
    applyStimulus("lh 0x63 forced", 1'b0, 32'h63, 32'h0, SZ_H, 1'b0, 32'h00001234, 1'b0);
    applyStimulus("lhu 0x61 forced", 1'b0, 32'h61, 32'h0, SZ_H, 1'b1, 32'h00005678, 1'b0);
    applyStimulus("lw 0x63 forced", 1'b0, 32'h63, 32'h0, SZ_W, 1'b0, 32'h12345678, 1'b0);
`endif

    $display("[TB] reset during wait");
    abortInWait("abort sw 0x70", 1'b1, 32'h70, 32'hCAFEF00D);
    applyStimulus("lw 0x70 kept", 1'b0, 32'h70, 32'h0, SZ_W, 1'b0, 32'hCAFEF00D, 1'b0);
    abortInWait("abort lw 0x64", 1'b0, 32'h64, 32'h0);
    applyStimulus("lw 0x64 after abort", 1'b0, 32'h64, 32'h0, SZ_W, 1'b0, 32'hBEEFFF19, 1'b0);

    $display("[TB] index wrap-around");
    applyStimulus("sw 0x400", 1'b1, 32'h400, 32'hA5A50001, SZ_W, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw 0x0 wrapped", 1'b0, 32'h0, 32'h0, SZ_W, 1'b0, 32'hA5A50001, 1'b0);
    applyStimulus("sw 0x4", 1'b1, 32'h4, 32'h00000011, SZ_W, 1'b0, 32'h0, 1'b0);
    applyStimulus("lw 0x404 wrapped", 1'b0, 32'h404, 32'h0, SZ_W, 1'b0, 32'h00000011, 1'b0);

    $display("[TB] zero-wait back-to-back");
    zRspReady = 1'b1;
    zReqValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      zReqWe       = zWeTab[i];
      zReqAddr     = zAddrTab[i];
      zReqWdata    = zWdataTab[i];
      zReqSize     = zSizeTab[i];
      zReqUnsigned = 1'b0;
      checkOutput("zero-wait req_ready", 32'(zReqReady), 32'd1);
      @(posedge clk); #1;
      checkOutput("zero-wait rsp_valid", 32'(zRspValid), 32'd1);
      checkOutput("zero-wait busy", 32'(zReqReady), 32'd0);
      checkOutput("zero-wait rdata", zRspRdata, zExpTab[i]);
      checkOutput("zero-wait err", 32'(zRspErr), 32'd0);
      @(posedge clk); #1;
      checkOutput("zero-wait rsp_valid drop", 32'(zRspValid), 32'd0);
    end
    zReqValid = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, data array size in 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, cycles between request acceptance and response valid (min 0).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, LSB-justified.
REQ-010 req_size  input  2  00 byte, 01 half, 10 word (funct3[1:0]); 11 illegal.
REQ-011 req_unsigned  input  1  zero-extend load data (lbu/lhu); ignored for stores and words.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator accepts response.
REQ-014 rsp_rdata  output  32  extended load data; 0 for stores.
REQ-015 rsp_err  output  1  access rejected (see Configuration).

Function
REQ-016 Request handshake SHALL complete on a clk edge with req_valid & req_ready; response SHALL complete on rsp_valid & rsp_ready.
REQ-017 FSM SHALL have states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-018 IDLE -> WAIT on accept when WAIT_CYCLES > 0; IDLE -> RESP directly when WAIT_CYCLES = 0.
REQ-019 WAIT SHALL count down from WAIT_CYCLES-1 and move to RESP when count = 0; accept-to-rsp_valid latency = WAIT_CYCLES+1 cycles.
REQ-020 RESP SHALL hold rsp_valid and rsp_rdata/rsp_err stable until rsp_ready; then -> IDLE (no same-cycle new accept).
REQ-021 Request fields SHALL be captured at accept; later changes to req_* SHALL NOT affect the transaction.
REQ-022 Word index = addr[31:2] modulo DEPTH (wrap-around, no error for out-of-range).
REQ-023 Stores SHALL write only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all) exactly once, on the accept edge.
REQ-024 Loads SHALL read at the accept edge, shift the addressed lanes to bit 0, then sign- or zero-extend per req_unsigned.
REQ-025 req_size = 11 SHALL be treated as an error: no write, rsp_rdata = 0, rsp_err = 1 (independent of macro).
REQ-026 Memory contents SHALL be unaffected by reset; no initialization other than testbench preload.

Reset
REQ-027 While reset = 0 at a clk edge: state = IDLE, counter = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-028 Reset mid-transaction SHALL abort it with no response; a store already accepted remains written.
REQ-029 First cycle after reset release SHALL show req_ready = 1.

Configuration
REQ-030 Macro DATA_MEM_RESPONDER_ALIGN_CHECK_EN defined: half access with addr[0]=1 or word access with addr[1:0]!=00 SHALL return rsp_err = 1, rsp_rdata = 0, no write.
REQ-031 Macro undefined: misaligned addresses SHALL be forced aligned (half clears addr[0], word clears addr[1:0]); rsp_err SHALL be 1 only for REQ-025.

Structure
REQ-032 Package riscv_mem_pkg SHALL hold the size enum (SIZE_B, SIZE_H, SIZE_W), the FSM state enum and lane-mask constants.
REQ-033 Sub-module mem_lane_align SHALL be combinational: produce the write byte-enable and the shifted write data, and extract and extend load data.
REQ-034 Storage SHALL be one DEPTH x 32 array with per-byte write enables.

Verification
REQ-035 Preload word 25 = 0x8899AABB; lb addr 0x64 -> rsp_rdata 0xFFFFFFBB; lbu addr 0x67 -> 0x00000088; lh addr 0x66 -> 0xFFFF8899.
REQ-036 sw 0x64 data 0x00000019, then sb 0x65 data 0xFF, then lw 0x64 -> 0x0000FF19; rsp_valid 3 cycles after each accept (WAIT_CYCLES=2).
REQ-037 Hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0 throughout; a new req_valid is not accepted.
REQ-038 Macro defined: lw addr 0x62 -> rsp_err 1, rdata 0, no write; macro undefined: sw addr 0x62 data 0x12345678 writes word 24, and lw 0x60 returns 0x12345678.
REQ-039 Assert reset = 0 during WAIT of a load -> rsp_valid never asserts; req_ready = 1 the cycle after release; sw 0x400 with DEPTH=256 writes word 0 (wrap-around).
REQ-040 WAIT_CYCLES = 0 build: back-to-back requests -> rsp_valid the cycle after accept, one transaction every 2 cycles with rsp_ready held high.
